// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default geometry, word-select encoding, slot position helper.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package i2s_pkg;

    localparam int DEF_DATA_W  = 24;
    localparam int DEF_SLOT_W  = 32;
    localparam int DEF_CLK_DIV = 4;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    // Bit position inside the current channel slot; p=0 is the I2S delay bit.
    function automatic int unsigned slot_pos(input int unsigned bit_cnt, input int unsigned slot_w);
        return bit_cnt % slot_w;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S master timing: SCK/WS generation, rise/fall strobes, bit counter, frame-end strobe.
// Latency: strobes are combinational from registered state; SCK/WS/bit_cnt update on the strobe edge.
// Backpressure: none; free-running while en=1, cleared to idle while en=0.
// Ports: clk, rst (sync, active-high), en | sck_out, ws_out, rise, fall, bit_cnt, frame_end.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter  int SLOT_W  = DEF_SLOT_W,
    parameter  int CLK_DIV = DEF_CLK_DIV,
    localparam int BIT_W   = $clog2(2 * SLOT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             sck_out,
    output logic             ws_out,
    output logic             rise,
    output logic             fall,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             frame_end
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(2 * SLOT_W - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tc;
    logic [BIT_W-1:0] bit_next;

    assign tc        = en && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise      = tc && !sck_out;
    assign fall      = tc && sck_out;
    assign frame_end = fall && (bit_cnt == LAST_BIT);
    assign bit_next  = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            sck_out <= 1'b0;
            ws_out  <= WS_LEFT;
            bit_cnt <= '0;
        end else if (tc) begin
            div_cnt <= '0;
            sck_out <= !sck_out;
            if (sck_out) begin
                // WS moves with the bit counter on SCK falling edges, as I2S slaves expect.
                bit_cnt <= bit_next;
                ws_out  <= (bit_next >= BIT_W'(SLOT_W)) ? WS_RIGHT : WS_LEFT;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_rx_stereo.sv
// I2S master stereo receiver: deserialises L/R slots and presents one pair per frame.
// Latency: pair valid the clk after the frame-wrap SCK fall; first frame after reset/enable dropped.
// Backpressure: valid/ready; an unaccepted pair is overwritten by the next frame and overrun sticks.
// Ports: clk, rst, en, sd_in, ready, overrun_clr | sck_out, ws_out, left_out, right_out, valid, overrun.
module i2s_rx_stereo
    import i2s_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SLOT_W  = DEF_SLOT_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sd_in,
    output logic              sck_out,
    output logic              ws_out,
    output logic [DATA_W-1:0] left_out,
    output logic [DATA_W-1:0] right_out,
    output logic              valid,
    input  logic              ready,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int BIT_W = $clog2(2 * SLOT_W);

    generate
        if (DATA_W < 1 || DATA_W >= SLOT_W || CLK_DIV < 2) begin : g_bad_params
            $error("i2s_rx_stereo: need 1 <= DATA_W < SLOT_W and CLK_DIV >= 2");
        end
    endgenerate

    logic             rise;
    logic             fall;
    logic             frame_end;
    logic [BIT_W-1:0] bit_cnt;

    i2s_clkgen #(
        .SLOT_W  (SLOT_W),
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sck_out   (sck_out),
        .ws_out    (ws_out),
        .rise      (rise),
        .fall      (fall),
        .bit_cnt   (bit_cnt),
        .frame_end (frame_end)
    );

    logic [DATA_W-1:0] sh_l;
    logic [DATA_W-1:0] sh_r;
    logic              first;
    logic              cap_en;
    logic              frame_done;
    logic              new_pair;
    logic              set_ovr;
    int unsigned       p;

    always_comb begin
        p      = slot_pos(32'(bit_cnt), SLOT_W);
        // Only slot bits 1..DATA_W carry the sample; p=0 is the I2S delay bit.
        cap_en = rise && (p >= 1) && (p <= unsigned'(DATA_W));
    end

    assign frame_done = fall && frame_end;
    assign new_pair   = frame_done && !first;
    assign set_ovr    = new_pair && valid && !ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_l      <= '0;
            sh_r      <= '0;
            first     <= 1'b1;
            left_out  <= '0;
            right_out <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (!en) begin
                // Partial frame is dropped; the next frame after re-enable is a warm-up frame.
                sh_l  <= '0;
                sh_r  <= '0;
                first <= 1'b1;
            end else if (cap_en) begin
                if (ws_out == WS_LEFT) begin
                    sh_l <= (sh_l << 1) | DATA_W'(sd_in);
                end else begin
                    sh_r <= (sh_r << 1) | DATA_W'(sd_in);
                end
            end

            if (frame_done && first) begin
                first <= 1'b0;
            end

            if (new_pair) begin
                left_out  <= sh_l;
                right_out <= sh_r;
            end

            if (new_pair) begin
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            if (set_ovr) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Bench for i2s_rx_stereo: mic model with frame scoreboard plus directed corner sequences.
// Latency: n/a.
// Backpressure: ready driven by the sequences below.
module tb_i2s_rx_stereo;

    localparam int DW    = 24;
    localparam int SW    = 32;
    localparam int CD    = 2;
    localparam int FRAME = 2 * SW * 2 * CD;

    typedef struct {
        logic [31:0] slot_l;
        logic [31:0] slot_r;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          en;
    logic          sd_in;
    logic          sck_out;
    logic          ws_out;
    logic [DW-1:0] left_out;
    logic [DW-1:0] right_out;
    logic          valid;
    logic          ready;
    logic          overrun;
    logic          overrun_clr;

    i2s_rx_stereo #(
        .DATA_W  (DW),
        .SLOT_W  (SW),
        .CLK_DIV (CD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sd_in       (sd_in),
        .sck_out     (sck_out),
        .ws_out      (ws_out),
        .left_out    (left_out),
        .right_out   (right_out),
        .valid       (valid),
        .ready       (ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    vec_t stim_q[$];
    vec_t exp_q[$];
    vec_t tbl[6];
    vec_t fill;
    vec_t mic_cur;
    int   mic_cnt   = 0;
    bit   mic_first = 1'b1;
    bit   mic_prev  = 1'b0;
    bit   sb_on     = 1'b1;
    bit   pulse_on  = 1'b1;
    int   sb_n      = 0;
    int   vrun      = 0;
    int   fv_cyc    = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Mic model: counts SCK falls, drives slot bit p (MSB of slot word at p=0), scoreboards frames.
    always @(negedge clk) begin
        logic [31:0] slot;
        vec_t        e;
        if (rst || !en) begin
            mic_cnt   = 0;
            mic_first = 1'b1;
            mic_cur   = fill;
        end else if (mic_prev && !sck_out) begin
            if (mic_cnt == 2 * SW - 1) begin
                if (!mic_first) exp_q.push_back(mic_cur);
                mic_first = 1'b0;
                if (stim_q.size() > 0) mic_cur = stim_q.pop_front();
                else mic_cur = fill;
                mic_cnt = 0;
            end else begin
                mic_cnt++;
            end
        end
        mic_prev = sck_out;
        slot  = (mic_cnt < SW) ? mic_cur.slot_l : mic_cur.slot_r;
        sd_in = slot[31 - (mic_cnt % SW)];

        if (valid && ready && sb_on) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pair", 32'(valid), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sb_left", {8'h0, left_out}, {8'h0, e.exp_l});
                chk("sb_right", {8'h0, right_out}, {8'h0, e.exp_r});
                sb_n++;
            end
        end
        if (valid && fv_cyc < 0) fv_cyc = cyc;
        if (valid) begin
            vrun++;
        end else begin
            if (vrun > 0 && pulse_on) chk("valid_pulse_len", 32'(vrun), 32'(1));
            vrun = 0;
        end
    end

    task automatic wait_valid_rise(input int maxc, output bit ok);
        int n = 0;
        while (valid && n < maxc) begin @(negedge clk); n++; end
        while (!valid && n < maxc) begin @(negedge clk); n++; end
        ok = valid;
    endtask

    initial begin
        int c0, r0, e1, t1, t2, falls, bad, cyc_b, w, n;
        bit ok, prev;

        fill = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 24'hFFFFFF, 24'hFFFFFF};
        mic_cur = fill;
        tbl[0] = '{32'hD2D2_D2FF, 32'h891A_2B7F, 24'hA5A5A5, 24'h123456};
        tbl[1] = '{32'h7FFF_FF80, 32'h4000_0000, 24'hFFFFFF, 24'h800000};
        tbl[2] = '{32'h4000_0000, 32'h7FFF_FF80, 24'h800000, 24'hFFFFFF};
        tbl[3] = '{32'h8000_007F, 32'hD2D2_D2FF, 24'h000000, 24'hA5A5A5};
        tbl[4] = '{32'h891A_2B7F, 32'h8000_00FF, 24'h123456, 24'h000001};
        tbl[5] = '{32'h8000_017F, 32'h8000_007F, 24'h000002, 24'h000000};

        rst = 1'b1; en = 1'b0; sd_in = 1'b0; ready = 1'b1; overrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sck", 32'(sck_out), 32'(0));
        chk("rst_ws", 32'(ws_out), 32'(0));
        chk("rst_left", {8'h0, left_out}, 32'h0);
        chk("rst_right", {8'h0, right_out}, 32'h0);
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));

        for (int i = 0; i < 6; i++) stim_q.push_back(tbl[i]);
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1; c0 = cyc;

        // SCK period
        n = 0;
        @(negedge clk);
        while (!sck_out && n < 20) begin @(negedge clk); n++; end
        t1 = cyc;
        while (sck_out && n < 20) begin @(negedge clk); n++; end
        while (!sck_out && n < 20) begin @(negedge clk); n++; end
        t2 = cyc;
        chk("sck_period", 32'(t2 - t1), 32'(2 * CD));

        // WS high for exactly one slot of SCK falls
        n = 0;
        while (!ws_out && n < 400) begin @(negedge clk); n++; end
        falls = 0; prev = sck_out;
        while (ws_out && n < 800) begin
            @(negedge clk); n++;
            if (prev && !sck_out) falls++;
            prev = sck_out;
        end
        chk("ws_slot_falls", 32'(falls), 32'(SW));

        // Table frames through the scoreboard
        n = 0;
        while (sb_n < 6 && n < 10 * FRAME) begin @(negedge clk); n++; end
        chk("table_frames", 32'(sb_n), 32'(6));
        chk("first_valid_cyc", 32'(fv_cyc - c0), 32'(2 * FRAME));

        // Overrun: two frames complete with ready low
        stim_q.push_back('{32'h8000_00FF, 32'h891A_2B7F, 24'h000001, 24'h123456});
        stim_q.push_back('{32'h8000_017F, 32'hD2D2_D2FF, 24'h000002, 24'hA5A5A5});
        stim_q.push_back(tbl[1]);
        wait_valid_rise(2 * FRAME, ok);
        chk("ovr_pre_valid", 32'(ok), 32'(1));
        @(posedge clk); #1;
        ready = 1'b0; sb_on = 1'b0; pulse_on = 1'b0;
        @(negedge clk);
        wait_valid_rise(2 * FRAME, ok);
        chk("ovr_a_valid", 32'(ok), 32'(1));
        chk("ovr_a_left", {8'h0, left_out}, 32'h000001);
        chk("ovr_a_overrun", 32'(overrun), 32'(0));
        n = 0;
        while (!overrun && n < 2 * FRAME) begin @(negedge clk); n++; end
        cyc_b = cyc;
        chk("ovr_b_overrun", 32'(overrun), 32'(1));
        chk("ovr_b_valid", 32'(valid), 32'(1));
        chk("ovr_b_left", {8'h0, left_out}, 32'h000002);
        chk("ovr_b_right", {8'h0, right_out}, 32'hA5A5A5);
        @(posedge clk); #1 overrun_clr = 1'b1;
        @(posedge clk); #1 overrun_clr = 1'b0;
        @(negedge clk);
        chk("ovr_clr", 32'(overrun), 32'(0));
        chk("ovr_clr_valid_held", 32'(valid), 32'(1));
        chk("ovr_clr_left_held", {8'h0, left_out}, 32'h000002);

        // ready high only on the frame-wrap edge while valid is pending
        while (cyc < cyc_b + FRAME - 2) @(negedge clk);
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        @(negedge clk);
        w = cyc_b + FRAME;
        chk("fe_ready_valid", 32'(valid), 32'(1));
        chk("fe_ready_left", {8'h0, left_out}, 32'hFFFFFF);
        chk("fe_ready_right", {8'h0, right_out}, 32'h800000);
        chk("fe_ready_overrun", 32'(overrun), 32'(0));

        // Reset mid-frame at bit_cnt=40
        while (cyc < w + 4 * 40 + 1) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_sck", 32'(sck_out), 32'(0));
        chk("mrst_ws", 32'(ws_out), 32'(0));
        chk("mrst_left", {8'h0, left_out}, 32'h0);
        chk("mrst_right", {8'h0, right_out}, 32'h0);
        chk("mrst_valid", 32'(valid), 32'(0));
        chk("mrst_overrun", 32'(overrun), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0; ready = 1'b1;
        stim_q.delete(); exp_q.delete();
        sb_on = 1'b1; r0 = cyc;
        @(negedge clk);
        wait_valid_rise(3 * FRAME, ok);
        chk("mrst_next_valid", 32'(ok), 32'(1));
        chk("mrst_next_valid_cyc", 32'(cyc - r0), 32'(2 * FRAME));

        // en low with a pending pair
        stim_q.push_back(tbl[0]);
        @(posedge clk); #1 ready = 1'b0;
        @(negedge clk);
        wait_valid_rise(2 * FRAME, ok);
        chk("en_pend_valid", 32'(ok), 32'(1));
        @(posedge clk); #1 en = 1'b0;
        @(posedge clk);
        bad = 0;
        repeat (99) begin
            @(negedge clk);
            if (sck_out !== 1'b0 || ws_out !== 1'b0) bad++;
        end
        chk("en_off_idle", 32'(bad), 32'(0));
        chk("en_off_valid_held", 32'(valid), 32'(1));
        n = sb_n;
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("en_off_accepted", 32'(sb_n - n), 32'(1));
        chk("en_off_valid_clr", 32'(valid), 32'(0));
        @(posedge clk); #1;
        en = 1'b1; e1 = cyc;
        @(negedge clk);
        wait_valid_rise(3 * FRAME, ok);
        chk("en_on_valid", 32'(ok), 32'(1));
        chk("en_on_valid_cyc", 32'(cyc - e1), 32'(2 * FRAME));
        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx_stereo.md
Name: i2s_rx_stereo

Overview:
Parametrised I2S master receiver for stereo MEMS microphones (one or two mics sharing SD). It generates SCK and WS from the system clock and deserialises left and right samples, aligned MSB-first with the standard one-bit I2S delay. Each completed frame is presented as a left/right pair under a valid/ready handshake, with sticky overrun detection. It sits between the microphone pins and the sample buffer/DSP path.

Parameters:
DATA_W, 24, captured sample width in bits (1..SLOT_W-1)
SLOT_W, 32, SCK cycles per channel slot; frame = 2*SLOT_W SCK cycles
CLK_DIV, 4, clk cycles per SCK half-period (>=2); f_sck = f_clk/(2*CLK_DIV)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
en  in  1  run enable; low stops SCK/WS generation
sd_in  in  1  serial data from microphone(s)
sck_out  out  1  generated bit clock to microphone(s)
ws_out  out  1  word select: 0 = left slot, 1 = right slot
left_out  out  DATA_W  left sample, two's complement, raw
right_out  out  DATA_W  right sample, two's complement, raw
valid  out  1  frame pair available
ready  in  1  consumer accepts pair when valid&&ready
overrun  out  1  sticky: an unaccepted frame was overwritten
overrun_clr  in  1  clears overrun

Behaviour:
- Reset values: sck_out=0, ws_out=0, left_out=0, right_out=0, valid=0, overrun=0; div_cnt=0, bit_cnt=0, shift registers=0, first-frame flag armed.
- Divider: while en=1, div_cnt counts 0..CLK_DIV-1. At terminal count, sck_out toggles and div_cnt returns to 0.
  - The 0->1 toggle cycle is the "rise" event; the 1->0 toggle cycle is the "fall" event.
- bit_cnt (0..2*SLOT_W-1) advances on each fall event and wraps to 0.
  - ws_out is registered on the same edge and equals 1 when the new bit_cnt >= SLOT_W. WS therefore changes on SCK falling edges.
- Capture: p = bit_cnt mod SLOT_W. On a rise event with 1 <= p <= DATA_W, sd_in is shifted into the left shift register when ws_out=0, otherwise into the right shift register.
  - Bits at p=0 and p>DATA_W are ignored.
  - sd_in is sampled in the rise-event cycle, one half SCK period after the mic launch edge.
- Frame completion: a fall event that wraps bit_cnt from 2*SLOT_W-1 to 0 loads left_out/right_out from the shift registers.
  - On that edge, valid is set, except for the first frame after reset or en re-assertion: that frame is discarded and the first-frame flag is cleared.
- Latency: valid is visible the clk cycle after the wrap edge, which is 2*SLOT_W*2*CLK_DIV clks per frame.
- Handshake: valid&&ready clears valid on the next edge. valid stays high and data stays stable until accepted.
- New frame while valid=1 and ready=0: outputs are overwritten with the new pair, valid stays 1, overrun sets.
- New frame in the same cycle as valid&&ready: new pair loads, valid stays 1, overrun unchanged.
- overrun_clr and an overrun-set event in the same cycle: set wins.
- en=0: div_cnt and bit_cnt are cleared, sck_out=0, ws_out=0, first-frame flag re-armed.
  - valid, left_out, right_out and overrun are held, so a pending pair can still be accepted.
  - Any partial frame is dropped.
- rst mid-frame: all state returns to reset values on that edge; no partial data is ever presented.
- A parameter check at elaboration fails if DATA_W >= SLOT_W or CLK_DIV < 2.

Decomposition:
- Shared package i2s_pkg holds:
  - default DATA_W/SLOT_W/CLK_DIV constants
  - WS_LEFT=0 and WS_RIGHT=1 constants
  - a function returning the slot position p from bit_cnt and SLOT_W
- One sub-module, i2s_clkgen (parameters SLOT_W, CLK_DIV), outputs sck_out, ws_out, rise/fall strobes, bit_cnt and a frame_end strobe. It is reused by the planned I2S transmitter.
- The top level holds the capture shift registers, output registers, handshake and overrun logic.

Test Plan:
- CLK_DIV=2, SLOT_W=32, rst then en=1 -> sck_out period 4 clks; ws_out toggles every 32 SCK falls; no valid during frame 0; first valid after frame 1 ends, at clk 512 + 1.
- Mic model drives left 0xA5A5A5 and right 0x123456 MSB at p=1, 1s at p=0 and p>24, ready=1 -> left_out=0xA5A5A5, right_out=0x123456; valid is a 1-cycle pulse per frame.
- ready=0 for two completed frames (L=0x000001/0x000002) -> overrun=1; left_out=0x000002; valid held. Then overrun_clr=1 -> overrun=0.
- ready=1 asserted exactly on a frame_end cycle with valid=1 -> new pair loaded, valid stays 1, overrun stays 0.
- rst asserted at bit_cnt=40 -> next cycle all outputs at reset values; next valid only after one discarded full frame.
- en=0 for 100 clks with valid=1 pending -> sck_out=0, ws_out=0; pending pair accepted intact; after en=1, one frame is discarded before the next valid.
